// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared MIPS subset definitions used by the instruction encoder and decoder:
// opcode/funct codes, the symbolic descriptor kinds, the encoder FSM states
// and small helpers that pack R-type and I-type instruction words.
// No ports (package).
// -----------------------------------------------------------------------------
package mips_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLTU = 6'b101011;

    // Descriptor kinds; codes 10..15 are illegal
    typedef enum logic [3:0] {
        K_ADDU  = 4'd0,
        K_SUBU  = 4'd1,
        K_AND   = 4'd2,
        K_OR    = 4'd3,
        K_SLTU  = 4'd4,
        K_LW    = 4'd5,
        K_SW    = 4'd6,
        K_BEQ   = 4'd7,
        K_ADDIU = 4'd8,
        K_J     = 4'd9
    } kind_e;

    // Encoder session states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } enc_state_e;

    // R-type word: shamt is always zero in this subset
    function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        pack_r = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
    endfunction

    // I-type word
    function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        pack_i = {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_pack.sv
// -----------------------------------------------------------------------------
// instr_pack
// Purely combinational: descriptor kind + fields -> 32-bit MIPS word and a
// legal flag. Only the fields belonging to the selected format are used, so
// stray values on unused fields never reach the word. Illegal kinds give a
// zero word with o_legal = 0.
// Ports:
//   i_kind    4   descriptor kind (kind_e codes, 10..15 illegal)
//   i_rs      5   instr[25:21]
//   i_rt      5   instr[20:16]
//   i_rd      5   instr[15:11] (R-type only)
//   i_imm     16  instr[15:0]  (I-type only)
//   i_target  26  instr[25:0]  (J only)
//   o_word    32  encoded instruction
//   o_legal   1   kind is part of the supported set
// -----------------------------------------------------------------------------
module instr_pack
    import mips_pkg::*;
(
    input  logic [3:0]  i_kind,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [15:0] i_imm,
    input  logic [25:0] i_target,
    output logic [31:0] o_word,
    output logic        o_legal
);

    // Format selection and field packing
    always_comb begin
        o_word  = 32'd0;
        o_legal = 1'b0;
        case (i_kind)
            K_ADDU:  begin o_word = pack_r(i_rs, i_rt, i_rd, F_ADDU);    o_legal = 1'b1; end
            K_SUBU:  begin o_word = pack_r(i_rs, i_rt, i_rd, F_SUBU);    o_legal = 1'b1; end
            K_AND:   begin o_word = pack_r(i_rs, i_rt, i_rd, F_AND);     o_legal = 1'b1; end
            K_OR:    begin o_word = pack_r(i_rs, i_rt, i_rd, F_OR);      o_legal = 1'b1; end
            K_SLTU:  begin o_word = pack_r(i_rs, i_rt, i_rd, F_SLTU);    o_legal = 1'b1; end
            K_LW:    begin o_word = pack_i(OP_LW,    i_rs, i_rt, i_imm); o_legal = 1'b1; end
            K_SW:    begin o_word = pack_i(OP_SW,    i_rs, i_rt, i_imm); o_legal = 1'b1; end
            K_BEQ:   begin o_word = pack_i(OP_BEQ,   i_rs, i_rt, i_imm); o_legal = 1'b1; end
            K_ADDIU: begin o_word = pack_i(OP_ADDIU, i_rs, i_rt, i_imm); o_legal = 1'b1; end
            K_J:     begin o_word = {OP_J, i_target};                    o_legal = 1'b1; end
            default: begin o_word = 32'd0;                               o_legal = 1'b0; end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Program loader: accepts symbolic instruction descriptors, encodes them to
// MIPS words and writes them to consecutive instruction-memory addresses
// starting at a session base address. One word per cycle, write port is
// registered (valid one cycle after the descriptor transfer).
// Ports:
//   clk, reset            clock / asynchronous active-high reset
//   start, base_addr      open a session at base_addr (only from IDLE)
//   in_valid, in_ready    descriptor handshake
//   in_kind..in_last      descriptor fields, in_last closes the session
//   imem_we/addr/wdata    instruction-memory write port
//   done                  one-cycle pulse at session end
//   err_illegal           sticky: an illegal kind was consumed
//   err_full              sticky: last address written without in_last
//   word_count            words written in this session
// -----------------------------------------------------------------------------
module instr_encoder
    import mips_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              done,
    output logic              err_illegal,
    output logic              err_full,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    enc_state_e        r_state;
    enc_state_e        w_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_ready;
    logic              r_done;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_err_illegal;
    logic              r_err_full;

    logic [31:0]       w_word;
    logic              w_legal;
    logic              w_xfer;
    logic              w_at_end;

    instr_pack u_pack (
        .i_kind   (in_kind),
        .i_rs     (in_rs),
        .i_rt     (in_rt),
        .i_rd     (in_rd),
        .i_imm    (in_imm),
        .i_target (in_target),
        .o_word   (w_word),
        .o_legal  (w_legal)
    );

    assign w_xfer   = in_valid && r_ready;
    assign w_at_end = (r_ptr == PTR_MAX);

    // Session state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a legal write at the last address closes the session
    // even without in_last because the pointer must not wrap
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_xfer && (in_last || (w_legal && w_at_end))) begin
                    w_next = S_FLUSH;
                end else begin
                    w_next = S_RUN;
                end
            end
            S_FLUSH: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Pointer, counters, sticky errors and the registered write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr         <= {ADDR_W{1'b0}};
            r_count       <= {(ADDR_W+1){1'b0}};
            r_ready       <= 1'b0;
            r_done        <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= {ADDR_W{1'b0}};
            r_wdata       <= 32'd0;
            r_err_illegal <= 1'b0;
            r_err_full    <= 1'b0;
        end else begin
            // Handshake and done are registered copies of the next state
            r_ready <= (w_next == S_RUN);
            r_done  <= (w_next == S_DONE);
            r_we    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ptr         <= base_addr;
                        r_count       <= {(ADDR_W+1){1'b0}};
                        r_err_illegal <= 1'b0;
                        r_err_full    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_xfer) begin
                        if (w_legal) begin
                            r_we    <= 1'b1;
                            r_addr  <= r_ptr;
                            r_wdata <= w_word;
                            r_count <= r_count + CNT_ONE;
                            if (w_at_end) begin
                                // Hold the pointer at the top; only flag full
                                // if the stream had more to give
                                r_err_full <= r_err_full | ~in_last;
                            end else begin
                                r_ptr <= r_ptr + PTR_ONE;
                            end
                        end else begin
                            r_err_illegal <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready    = r_ready;
    assign done        = r_done;
    assign imem_we     = r_we;
    assign imem_addr   = r_addr;
    assign imem_wdata  = r_wdata;
    assign err_illegal = r_err_illegal;
    assign err_full    = r_err_full;
    assign word_count  = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_kind;
    logic [4:0]    in_rs, in_rt, in_rd;
    logic [15:0]   in_imm;
    logic [25:0]   in_target;
    logic          in_last;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          done;
    logic          err_illegal;
    logic          err_full;
    logic [AW:0]   word_count;

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    kind;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .done(done), .err_illegal(err_illegal), .err_full(err_full),
        .word_count(word_count)
    );

    // Reference encoding straight from the instruction formats
    function automatic logic [31:0] enc(input logic [3:0] k, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [15:0] imm, input logic [25:0] tg);
        case (k)
            4'd0:    enc = {6'b000000, rs, rt, rd, 5'b00000, 6'b100001};
            4'd1:    enc = {6'b000000, rs, rt, rd, 5'b00000, 6'b100011};
            4'd2:    enc = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
            4'd3:    enc = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
            4'd4:    enc = {6'b000000, rs, rt, rd, 5'b00000, 6'b101011};
            4'd5:    enc = {6'b100011, rs, rt, imm};
            4'd6:    enc = {6'b101011, rs, rt, imm};
            4'd7:    enc = {6'b000100, rs, rt, imm};
            4'd8:    enc = {6'b001001, rs, rt, imm};
            4'd9:    enc = {6'b000010, tg};
            default: enc = 32'd0;
        endcase
    endfunction

    // Decoder side of the round trip: recover the kind from a word
    function automatic logic [3:0] dec_kind(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100001: dec_kind = 4'd0;
                    6'b100011: dec_kind = 4'd1;
                    6'b100100: dec_kind = 4'd2;
                    6'b100101: dec_kind = 4'd3;
                    6'b101011: dec_kind = 4'd4;
                    default:   dec_kind = 4'd15;
                endcase
            end
            6'b100011: dec_kind = 4'd5;
            6'b101011: dec_kind = 4'd6;
            6'b000100: dec_kind = 4'd7;
            6'b001001: dec_kind = 4'd8;
            6'b000010: dec_kind = 4'd9;
            default:   dec_kind = 4'd15;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; afterwards the write port must match the scoreboard head
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("we", 64'(imem_we), 64'd1);
            chk("addr", 64'(imem_addr), 64'(e.addr));
            chk("data", 64'(imem_wdata), 64'(e.data));
            chk("roundtrip_kind", 64'(dec_kind(imem_wdata)), 64'(e.kind));
        end else begin
            chk("no_we", 64'(imem_we), 64'd0);
        end
    endtask

    task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tg,
                        input logic last, input logic [31:0] exp_word);
        in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd;
        in_imm = imm; in_target = tg; in_last = last;
        in_valid = 1'b1;
        for (int i = 0; i < 16 && in_ready !== 1'b1; i++) tick();
        chk("ready", 64'(in_ready), 64'd1);
        if (k <= 4'd9) begin
            exp_q.push_back('{addr: model_ptr[AW-1:0], data: exp_word, kind: k});
            model_ptr++;
        end
        tick();
    endtask

    task automatic start_session(input logic [AW-1:0] base);
        in_valid  = 1'b0;
        start     = 1'b1;
        base_addr = base;
        tick();
        start     = 1'b0;
        base_addr = base ^ 6'h15;
        model_ptr = int'(base);
        chk("ready_after_start", 64'(in_ready), 64'd1);
        chk("wc_clear", 64'(word_count), 64'd0);
        chk("ill_clear", 64'(err_illegal), 64'd0);
        chk("full_clear", 64'(err_full), 64'd0);
    endtask

    // Called right after the closing transfer's cycle
    task automatic finish_session(input int wc, input logic ill, input logic full);
        chk("ready_flush", 64'(in_ready), 64'd0);
        chk("done_early", 64'(done), 64'd0);
        tick();
        chk("done", 64'(done), 64'd1);
        tick();
        chk("done_end", 64'(done), 64'd0);
        chk("word_count", 64'(word_count), 64'(wc));
        chk("err_illegal", 64'(err_illegal), 64'(ill));
        chk("err_full", 64'(err_full), 64'(full));
        chk("ready_idle", 64'(in_ready), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  rk;
        logic [4:0]  r1, r2, r3;
        logic [15:0] ri;
        logic [25:0] rtg;

        reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_imm = '0; in_target = '0; in_last = 1'b0;
        tick();
        tick();
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_addr", 64'(imem_addr), 64'd0);
        chk("rst_wdata", 64'(imem_wdata), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_errs", 64'({err_illegal, err_full}), 64'd0);
        chk("rst_wc", 64'(word_count), 64'd0);
        reset = 1'b0;
        in_valid = 1'b1;   // not accepted while idle
        tick();
        chk("idle_no_ready", 64'(in_ready), 64'd0);

        // 1: single ADDU
        start_session(6'd0);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h00221821);
        finish_session(1, 1'b0, 1'b0);

        // 2: I-types and J with garbage in unused fields; start mid-session ignored
        start_session(6'd4);
        send(4'd5, 5'd29, 5'd8, 5'd31, 16'hFFFC, 26'h3FFFFFF, 1'b0, 32'h8FA8FFFC);
        send(4'd6, 5'd29, 5'd8, 5'd31, 16'hFFFC, 26'h3FFFFFF, 1'b0, 32'hAFA8FFFC);
        in_valid = 1'b0; start = 1'b1; base_addr = 6'd50;
        tick();
        start = 1'b0;
        send(4'd7, 5'd1, 5'd2, 5'd17, 16'h0003, 26'h2AAAAAA, 1'b0, 32'h10220003);
        send(4'd8, 5'd0, 5'd5, 5'd31, 16'h0007, 26'h3FFFFFF, 1'b0, 32'h24050007);
        send(4'd9, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000010, 1'b1, 32'h08000010);
        finish_session(5, 1'b0, 1'b0);

        // 3: illegal kind between two ADDIU
        start_session(6'd10);
        send(4'd8, 5'd3, 5'd4, 5'd9, 16'h0011, 26'h1234567, 1'b0, 32'h24640011);
        send(4'd12, 5'd7, 5'd7, 5'd7, 16'h7777, 26'h0777777, 1'b0, 32'd0);
        send(4'd8, 5'd0, 5'd5, 5'd0, 16'h0007, 26'h0, 1'b1, 32'h24050007);
        finish_session(2, 1'b1, 1'b0);
        chk("err_hold", 64'(err_illegal), 64'd1);

        // 4: memory end reached without last
        start_session(6'd62);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 32'h00221821);
        send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0, 32'h00853023);
        in_kind = 4'd0; in_rs = 5'd9; in_valid = 1'b1; in_last = 1'b0;
        chk("full_flag_now", 64'(err_full), 64'd1);
        finish_session(2, 1'b0, 1'b1);
        in_valid = 1'b0;

        // 4b: full and last together
        start_session(6'd63);
        send(4'd0, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0, 1'b1, 32'h00E84821);
        finish_session(1, 1'b0, 1'b0);

        // 5: random descriptors with random input gaps
        start_session(6'd20);
        for (int i = 0; i < 12; i++) begin
            rk  = 4'($urandom_range(0, 9));
            r1  = 5'($urandom); r2 = 5'($urandom); r3 = 5'($urandom);
            ri  = 16'($urandom); rtg = 26'($urandom);
            send(rk, r1, r2, r3, ri, rtg, (i == 11), enc(rk, r1, r2, r3, ri, rtg));
            if (i != 11 && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                tick();
            end
        end
        finish_session(12, 1'b0, 1'b0);

        // 6: reset mid-session, then a fresh session
        start_session(6'd30);
        send(4'd0, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b0, enc(4'd0, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0));
        send(4'd3, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0, 1'b0, enc(4'd3, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0));
        reset = 1'b1;
        #1;
        chk("rst_mid_we", 64'(imem_we), 64'd0);
        chk("rst_mid_ready", 64'(in_ready), 64'd0);
        chk("rst_mid_wc", 64'(word_count), 64'd0);
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("post_rst_idle", 64'(in_ready), 64'd0);
        start_session(6'd40);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 32'h00221821);
        finish_session(1, 1'b0, 1'b0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
